pt_ring_link_tx: RTL and testbench

//  Egress side of a PtRing stop. Pops flits from the local two-entry

---
 rtl/pt_ring_link_tx.sv | 100 ++++++++++
 tb/tb_pt_ring_link_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_ring_link_tx.sv
// PtRing stop egress: pops flits from the local show-ahead FIFO onto the ring link under
// credit flow control, never splitting packets. Optional parity output: PT_RING_TX_PARITY_EN.
module pt_ring_link_tx #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 2,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iTxEn,
  input  logic             iFifoEmpty,
  input  logic [WIDTH-1:0] iFifoRdDat,
  output logic             oFifoRdEn,
  output logic             oLinkVld,
  output logic [WIDTH-1:0] oLinkDat,
  input  logic             iLinkCrdRet,
  output logic [CW-1:0]    oCrdCnt,
  output logic             oBusy,
  output logic             oCrdErr
`ifdef PT_RING_TX_PARITY_EN
  ,
  output logic             oLinkPar
`endif
);

  // Handshake: a flit moves when the FIFO is non-empty (valid) and the link side is ready
  // (credit available and packet gating open); oFifoRdEn pops it on the same edge it is launched.
  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

  localparam logic [CW-1:0] CRD_MAX = CW'(CREDITS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             err_q, err_d;
  logic             send;
  logic             tail;

  always_comb begin
    tail    = iFifoRdDat[WIDTH-1];
    send    = !iFifoEmpty && (cnt_q != '0) &&
              ((state_q == PKT) || ((state_q == IDLE) && iTxEn));
    state_d = state_q;
    vld_d   = send;
    dat_d   = send ? iFifoRdDat : dat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (send) state_d = tail ? IDLE : PKT;
    // A return with no credit outstanding is a downstream protocol error; keep the count saturated.
    case ({send, iLinkCrdRet})
      2'b10:   cnt_d = cnt_q - 1'b1;
      2'b01: begin
        if (cnt_q == CRD_MAX) err_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef PT_RING_TX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = send ? ^iFifoRdDat : par_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  assign oLinkPar = par_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CRD_MAX;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end

  // The pop strobe is combinational, so it must be gated by reset explicitly.
  assign oFifoRdEn = send && rst;
  assign oLinkVld  = vld_q;
  assign oLinkDat  = dat_q;
  assign oCrdCnt   = cnt_q;
  assign oBusy     = (state_q == PKT);
  assign oCrdErr   = err_q;

endmodule

// File: tb/tb_pt_ring_link_tx.sv
// Bench for pt_ring_link_tx: a transaction-level model (flit queue, integer credit count,
// in-packet flag) checked against the DUT every negedge, plus directed literal expectations.
module tb_pt_ring_link_tx;

  localparam int CREDITS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       iTxEn;
  logic       iFifoEmpty;
  logic [7:0] iFifoRdDat;
  logic       oFifoRdEn;
  logic       oLinkVld;
  logic [7:0] oLinkDat;
  logic       iLinkCrdRet;
  logic [1:0] oCrdCnt;
  logic       oBusy;
  logic       oCrdErr;
`ifdef PT_RING_TX_PARITY_EN
  logic       oLinkPar;
`endif

  pt_ring_link_tx #(.WIDTH(8), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst), .iTxEn(iTxEn), .iFifoEmpty(iFifoEmpty), .iFifoRdDat(iFifoRdDat),
    .oFifoRdEn(oFifoRdEn), .oLinkVld(oLinkVld), .oLinkDat(oLinkDat),
    .iLinkCrdRet(iLinkCrdRet), .oCrdCnt(oCrdCnt), .oBusy(oBusy), .oCrdErr(oCrdErr)
`ifdef PT_RING_TX_PARITY_EN
    , .oLinkPar(oLinkPar)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] src_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int         busy_cnt = 0;
  int         cyc      = 0;
  bit         auto_ret = 1'b0;

  // transaction-level model state (values visible on the DUT outputs this cycle)
  bit       m_vld, m_pkt, m_err, m_par;
  bit [7:0] m_dat;
  int       m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    iFifoEmpty = (src_q.size() == 0);
    iFifoRdDat = (src_q.size() == 0) ? 8'h00 : src_q[0];
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] f);
    src_q.push_back(f);
    refresh();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    busy_cnt = 0;
  endtask

  // FIFO pins follow the bench queue; downstream optionally returns a credit per arriving flit
  always begin
    @(posedge clk);
    #1;
    refresh();
    if (auto_ret) iLinkCrdRet = m_vld;
  end

  // scoreboard: compare every cycle, then advance the model across the coming edge
  always @(negedge clk) begin
    bit       exp_send;
    bit [7:0] head;
    cyc++;
    if (!rst) begin
      m_vld = 0; m_dat = 8'h00; m_cnt = CREDITS; m_pkt = 0; m_err = 0; m_par = 0;
    end
    exp_send = rst && (src_q.size() != 0) && (m_cnt > 0) && (m_pkt || iTxEn);
    check("rden", oFifoRdEn, exp_send);
    check("vld", oLinkVld, m_vld);
    check("dat", oLinkDat, m_dat);
    check("crd", oCrdCnt, m_cnt);
    check("busy", oBusy, m_pkt);
    check("crderr", oCrdErr, m_err);
`ifdef PT_RING_TX_PARITY_EN
    check("par", oLinkPar, m_par);
`endif
    if (rst) begin
      if (oLinkVld) begin
        obs_q.push_back(oLinkDat);
        obs_cyc.push_back(cyc);
      end
      if (oBusy) busy_cnt++;
      m_cnt = m_cnt - int'(exp_send) + int'(iLinkCrdRet);
      if (m_cnt > CREDITS) begin
        m_cnt = CREDITS;
        m_err = 1;
      end
      m_vld = exp_send;
      if (exp_send) begin
        head  = src_q.pop_front();
        m_dat = head;
        m_par = ^head;
        m_pkt = !head[7];
      end
    end
  end

  initial begin
    rst = 1'b1; iTxEn = 1'b0; iLinkCrdRet = 1'b0;
    refresh();
    #2 rst = 1'b0;
    tick(2);
    rst = 1'b1;

    // 1: two-flit packet, credits returned behind it
    iTxEn = 1'b1;
    clear_obs();
    push(8'h01); push(8'h82);
    tick(1);
    iLinkCrdRet = 1'b1;
    tick(2);
    iLinkCrdRet = 1'b0;
    tick(2);
    check("t1_nflits", obs_q.size(), 2);
    check("t1_f0", obs_q[0], 8'h01);
    check("t1_f1", obs_q[1], 8'h82);
    check("t1_b2b", obs_cyc[1] - obs_cyc[0], 1);
    check("t1_busycyc", busy_cnt, 1);
    check("t1_crd", oCrdCnt, 2);

    // 2: credits exhausted after two single-flit packets
    clear_obs();
    push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    tick(4);
    check("t2_crd0", oCrdCnt, 0);
    check("t2_rden0", oFifoRdEn, 0);
    check("t2_nflits", obs_q.size(), 2);
    check("t2_f1", obs_q[1], 8'h82);
    iLinkCrdRet = 1'b1;
    tick(1);
    iLinkCrdRet = 1'b0;
    tick(1);
    check("t2_vld83", oLinkVld, 1);
    check("t2_dat83", oLinkDat, 8'h83);

    // 3: simultaneous send and return, then overflow return
    iLinkCrdRet = 1'b1;
    tick(2);
    iLinkCrdRet = 1'b0;
    check("t3_crd1", oCrdCnt, 1);
    check("t3_dat84", oLinkDat, 8'h84);
    iLinkCrdRet = 1'b1;
    tick(1);
    iLinkCrdRet = 1'b0;
    tick(1);
    check("t3_crd2", oCrdCnt, 2);
    check("t3_noerr", oCrdErr, 0);
    iLinkCrdRet = 1'b1;
    tick(1);
    iLinkCrdRet = 1'b0;
    tick(1);
    check("t3_err", oCrdErr, 1);
    check("t3_crdsat", oCrdCnt, 2);
    tick(3);
    check("t3_sticky", oCrdErr, 1);

    // 4: enable dropped after the head flit
    auto_ret = 1'b1;
    clear_obs();
    push(8'h10); push(8'h11); push(8'h92);
    tick(1);
    iTxEn = 1'b0;
    push(8'h85);
    tick(5);
    check("t4_nopop", oFifoRdEn, 0);
    check("t4_idle", oBusy, 0);
    check("t4_nflits", obs_q.size(), 3);
    check("t4_tail", obs_q[2], 8'h92);
    iTxEn = 1'b1;
    tick(3);
    check("t4_nflits2", obs_q.size(), 4);
    check("t4_f85", obs_q[3], 8'h85);

    // 5: FIFO runs dry mid-packet
    clear_obs();
    push(8'h20);
    tick(4);
    check("t5_busy", oBusy, 1);
    check("t5_novld", oLinkVld, 0);
    push(8'hA1);
    tick(2);
    check("t5_nflits", obs_q.size(), 2);
    check("t5_fA1", obs_q[1], 8'hA1);
    check("t5_idle", oBusy, 0);

    // 6: reset in the middle of a packet, then parity flits
    clear_obs();
    push(8'h30); push(8'h31);
    tick(1);
    #2;
    rst = 1'b0;
    src_q.delete();
    refresh();
    #1;
    check("t6_vld", oLinkVld, 0);
    check("t6_dat", oLinkDat, 0);
    check("t6_busy", oBusy, 0);
    check("t6_crd", oCrdCnt, 2);
    check("t6_err", oCrdErr, 0);
    check("t6_rden", oFifoRdEn, 0);
    tick(2);
    rst = 1'b1;
    clear_obs();
    push(8'h03);
    tick(2);
    check("t6_dat03", oLinkDat, 8'h03);
`ifdef PT_RING_TX_PARITY_EN
    check("t6_par03", oLinkPar, 0);
`endif
    push(8'h83);
    tick(2);
    check("t6_dat83", oLinkDat, 8'h83);
`ifdef PT_RING_TX_PARITY_EN
    check("t6_par83", oLinkPar, 1);
`endif
    tick(2);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
